ps2_kbd_rx: RTL and testbench
=============================

# ps2_kbd_rx

Parametrised PS/2 keyboard receiver that samples the raw PS/2 clock and data lines in the system clock domain. Each received 11-bit frame is checked for start, parity and stop bits, and E0/F0 prefixes are folded into one event per key (extended, break, code). Events go into a configurable-depth FIFO with a valid/ready output port. The block sits between the PS/2 pins and the keyboard consumer: the scan-code decoder, the segment display driver or a CPU MMIO register.

## Interface
Parameters:
- FIFO_DEPTH, 8: event FIFO depth; power of two, minimum 2.
- SYNC_STAGES, 3: synchronizer flops on ps2_clk and ps2_data; minimum 2.
- TIMEOUT_CYCLES, 50000: clk cycles with no falling ps2_clk edge, mid-frame, before the frame is aborted.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock (asynchronous).
- ps2_data  in  1  raw PS/2 data (asynchronous).
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the head event.
- out_data  out  10  head event: [9]=ext, [8]=brk, [7:0]=scan code.
- level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky; set when an event is dropped.
- frame_err  out  1  one-cycle pulse on a bad frame or a timeout.
- err_cnt  out  8  saturating count of frame_err pulses.
- brk_cnt  out  8  wrapping count of break events pushed.

## Operation
- Synchronization: ps2_clk and ps2_data pass through SYNC_STAGES flops each, with identical delay. The strobe asserts for one cycle when the synchronized clock goes 1->0. On that cycle the synchronized data bit is sampled.
- Frame capture:
  - A bit counter (0..10) stores bits 0..9 into a shift buffer.
  - On the strobe with counter==10, the frame is good only if all three hold: bit0==0, parity bit makes bits[9:1] odd, and the current data bit (stop)==1.
  - The counter returns to 0 on that strobe whether or not the frame is good.
- A bad frame is discarded, pulses frame_err and clears both prefix flags.
- Timeout:
  - A cycle counter runs while bit counter!=0 and resets on every strobe.
  - When it reaches TIMEOUT_CYCLES, the bit counter returns to 0, frame_err pulses and the prefix flags clear.
  - The timer is idle while bit counter==0.
- Prefix decoder (acts on good bytes):
  - 0xE0 sets ext_pend.
  - 0xF0 sets brk_pend.
  - Any other byte pushes {ext_pend, brk_pend, byte} and clears both flags.
  - Prefix bytes are never pushed.
  - 0xE0 F0 xx and 0xF0 alone behave consistently: flags accumulate until a non-prefix byte arrives.
- FIFO: show-ahead; out_data is valid whenever out_valid=1.
  - A pop occurs on any cycle with out_valid && out_ready.
  - Pointers wrap modulo FIFO_DEPTH. level is the exact count, 0..FIFO_DEPTH.
- Push when full:
  - Without a simultaneous pop, the event is dropped, overflow sets and the FIFO is unchanged.
  - With a simultaneous pop, the push is accepted and level stays FIFO_DEPTH.
- Counters:
  - brk_cnt increments on each accepted or dropped push with brk=1.
  - err_cnt stops at 255.
- Reset (async, any time, including mid-frame):
  - All of the following clear: pointers, level, bit counter, timer, prefix flags, synchronizers (to 1, the line idle state), overflow and both counters.
  - All outputs are 0 during and after reset until new traffic arrives.

## Timing
- Raw ps2_clk falling edge -> strobe: SYNC_STAGES+1 clk cycles.
- Stop-bit strobe at cycle N:
  - Good byte is registered at N+1.
  - Push occurs at N+1.
  - out_valid and level update at N+2.
- frame_err: high for exactly one cycle.
  - Bad frame: at N+1.
  - Timeout: on the cycle after the timer reaches TIMEOUT_CYCLES.
- Pop: out_data and level update on the cycle after the accepting edge. Back-to-back pops run at one per cycle.
- A strobe on the same cycle the timeout fires takes priority: the bit is captured and the timer resets.
- Events appear in arrival order. Nothing stalls reception: the PS/2 device is never inhibited.

## Test plan
- Reset, then frame 0x1C (A make) at 10 kHz PS/2 clock -> out_valid at stop strobe+2, out_data=0x01C, level=1. Pop -> out_valid=0, level=0.
- Sequence F0 1C -> single event 0x11C and brk_cnt=1. Sequence E0 F0 75 -> single event 0x375 and brk_cnt=2. No event for any prefix byte.
- Frame 0x1C with even parity, then frame 0x1C with stop bit=0 -> two frame_err pulses, err_cnt=2, nothing pushed. A following good 0x32 -> 0x032 pushed.
- FIFO_DEPTH=4, out_ready=0:
  - Send 5 make codes 0x10..0x14 -> level=4 and overflow=1.
  - Pop sequence returns 0x010..0x013.
  - Repeat with a pop on the same cycle as the 5th push -> overflow stays 0 and 0x014 is retained.
- Send 5 bits, then stop ps2_clk for TIMEOUT_CYCLES -> one frame_err pulse and the bit counter back to 0. A following full frame 0x2A -> event 0x02A.
- Assert rst after the 6th bit of a frame while the FIFO holds 2 events -> all outputs 0 immediately. After release, a clean frame 0x1C -> event 0x01C only.

Source files
------------

// File: rtl/ps2_kbd_rx_if.sv
// ps2_kbd_rx_if: valid/ready event port of the PS/2 keyboard receiver.
//   out_valid  head event present (FIFO non-empty)
//   out_ready  consumer accepts the head event this cycle
//   out_data   head event: [9]=ext, [8]=brk, [7:0]=scan code
// master = receiver (producer), slave = consumer.
interface ps2_kbd_rx_if;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard receiver. Synchronizes the raw PS/2 lines,
// captures 11-bit frames, folds E0/F0 prefixes into one event per key and
// queues the events in a show-ahead FIFO.
//   clk, rst        system clock, async active-high reset
//   ps2_clk/data    raw PS/2 lines (asynchronous)
//   out_if          event port (valid/ready/data)
//   level           FIFO occupancy 0..FIFO_DEPTH
//   overflow        sticky, an event was dropped on a full FIFO
//   frame_err       one-cycle pulse on a bad frame or a timeout
//   err_cnt         saturating count of frame_err pulses
//   brk_cnt         wrapping count of break events pushed (accepted or dropped)
module ps2_kbd_rx #(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned SYNC_STAGES    = 3,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ps2_clk,
  input  logic                        ps2_data,
  ps2_kbd_rx_if.master                out_if,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        overflow,
  output logic                        frame_err,
  output logic [7:0]                  err_cnt,
  output logic [7:0]                  brk_cnt
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]  EXT_CODE = 8'hE0;
  localparam logic [7:0]  BRK_CODE = 8'hF0;

  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   clk_last;
  logic                   strobe_c, bit_c;

  logic [3:0]             bit_cnt;
  logic [9:0]             shift;
  logic [TMR_W-1:0]       timer;
  logic                   frame_good_c, timeout_c;
  logic [7:0]             byte_q;
  logic                   byte_v;
  logic                   ext_pend, brk_pend;

  logic [9:0]             mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic                   push_c, pop_c, full_c, wr_en_c, drop_c;
  logic [9:0]             push_data_c;
  logic [LVL_W-1:0]       level_nxt_c;

  // Line synchronizers, reset to the idle-high line state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_last  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_last  <= clk_sync[SYNC_STAGES-1];
    end
  end

  // Falling-edge strobe and frame checks
  always_comb begin
    strobe_c     = clk_last & ~clk_sync[SYNC_STAGES-1];
    bit_c        = data_sync[SYNC_STAGES-1];
    frame_good_c = ~shift[0] & (^shift[9:1]) & bit_c;
    timeout_c    = (bit_cnt != 4'd0) && (timer == TMR_W'(TIMEOUT_CYCLES)) && !strobe_c;
  end

  // Frame capture, watchdog and error accounting; a strobe beats the timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt   <= 4'd0;
      shift     <= 10'd0;
      timer     <= '0;
      byte_q    <= 8'd0;
      byte_v    <= 1'b0;
      frame_err <= 1'b0;
      err_cnt   <= 8'd0;
    end else begin
      byte_v    <= 1'b0;
      frame_err <= 1'b0;
      if (strobe_c) begin
        timer <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt <= 4'd0;
          if (frame_good_c) begin
            byte_v <= 1'b1;
            byte_q <= shift[8:1];
          end else begin
            frame_err <= 1'b1;
          end
        end else begin
          shift[bit_cnt] <= bit_c;
          bit_cnt        <= bit_cnt + 4'd1;
        end
      end else if (timeout_c) begin
        bit_cnt   <= 4'd0;
        timer     <= '0;
        frame_err <= 1'b1;
      end else if (bit_cnt != 4'd0) begin
        timer <= timer + TMR_W'(1);
      end
      if (frame_err && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;
    end
  end

  // Prefix flags: accumulate until a non-prefix byte or an error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else if (frame_err) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else if (byte_v) begin
      if (byte_q == EXT_CODE) begin
        ext_pend <= 1'b1;
      end else if (byte_q == BRK_CODE) begin
        brk_pend <= 1'b1;
      end else begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end
    end
  end

  // FIFO control; a push into a full FIFO survives only with a same-cycle pop
  always_comb begin
    push_c      = byte_v && (byte_q != EXT_CODE) && (byte_q != BRK_CODE);
    push_data_c = {ext_pend, brk_pend, byte_q};
    full_c      = (level == LVL_W'(FIFO_DEPTH));
    pop_c       = out_if.out_valid && out_if.out_ready;
    wr_en_c     = push_c && (!full_c || pop_c);
    drop_c      = push_c && full_c && !pop_c;
    level_nxt_c = level + LVL_W'(wr_en_c) - LVL_W'(pop_c);
    out_if.out_data = out_if.out_valid ? mem[rd_ptr] : 10'd0;
  end

  // Event storage (no reset needed, reads are gated by out_valid)
  always_ff @(posedge clk) begin
    if (wr_en_c)
      mem[wr_ptr] <= push_data_c;
  end

  // Pointers, occupancy and status counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      level            <= '0;
      out_if.out_valid <= 1'b0;
      overflow         <= 1'b0;
      brk_cnt          <= 8'd0;
    end else begin
      if (wr_en_c)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)
        rd_ptr <= rd_ptr + PTR_W'(1);
      level            <= level_nxt_c;
      out_if.out_valid <= (level_nxt_c != '0);
      if (drop_c)
        overflow <= 1'b1;
      if (push_c && brk_pend)
        brk_cnt <= brk_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb_ps2_kbd_rx: directed and randomized PS/2 frames against a queue-based
// event model; a monitor pops and compares whenever the DUT hands off an event.
module tb_ps2_kbd_rx;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned SYNC  = 3;
  localparam int unsigned TMO   = 200;
  localparam int unsigned HALF  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [2:0] level;
  logic       overflow, frame_err;
  logic [7:0] err_cnt, brk_cnt;

  ps2_kbd_rx_if bus();

  ps2_kbd_rx #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .out_if(bus), .level(level), .overflow(overflow), .frame_err(frame_err),
    .err_cnt(err_cnt), .brk_cnt(brk_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [9:0] exp_q[$];
  bit         m_ext, m_brk, m_ovf;
  int         m_err_total, m_err_rst, m_brk_cnt;
  int         err_cycles;
  int         checks, passed;
  bit         rdy_rand, rdy_force;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Ready is only ever changed just after a rising edge
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
    end
  end

  // Monitor: every handshake pops the oldest expected event
  always @(negedge clk) begin
    if (frame_err) err_cycles++;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) check("spurious_event", exp_q.size(), 1);
      else check("pop_data", int'(bus.out_data), int'(exp_q.pop_front()));
    end
  end

  task automatic model_abort();
    m_err_total++;
    m_err_rst++;
    m_ext = 1'b0;
    m_brk = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] b, input bit good);
    if (!good) model_abort();
    else if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      if (m_brk) m_brk_cnt++;
      if (exp_q.size() >= int'(DEPTH)) m_ovf = 1'b1;
      else exp_q.push_back({m_ext, m_brk, b});
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ext = 1'b0; m_brk = 1'b0; m_ovf = 1'b0;
    m_err_rst = 0; m_brk_cnt = 0;
  endtask

  // Device-side frame: data changes while clock is high, host samples on the fall
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits, input bit pop_at_push);
    logic [10:0] fr;
    fr[0]   = 1'b0;
    fr[8:1] = b;
    fr[9]   = ~(^b) ^ bad_par;
    fr[10]  = ~bad_stop;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2_data = fr[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10) begin
        // Push lands on the 5th rising edge after the raw fall
        repeat (4) @(posedge clk);
        if (pop_at_push) rdy_force = 1'b1;
        @(posedge clk);
        if (pop_at_push) rdy_force = 1'b0;
        #2;
        model_frame(b, !(bad_par || bad_stop));
      end
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic good(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 11, 1'b0);
  endtask

  task automatic drain();
    rdy_force = 1'b1;
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
    check("drain_left", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    check("drain_level", int'(level), 0);
    check("drain_valid", int'(bus.out_valid), 0);
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_err_cnt"}, int'(err_cnt), (m_err_rst > 255) ? 255 : m_err_rst);
    check({tag, "_brk_cnt"}, int'(brk_cnt), m_brk_cnt % 256);
    check({tag, "_overflow"}, int'(overflow), int'(m_ovf));
    check({tag, "_err_pulses"}, err_cycles, m_err_total);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, int'(bus.out_valid), 0);
    check({tag, "_data"}, int'(bus.out_data), 0);
    check({tag, "_level"}, int'(level), 0);
    check({tag, "_overflow"}, int'(overflow), 0);
    check({tag, "_frame_err"}, int'(frame_err), 0);
    check({tag, "_err_cnt"}, int'(err_cnt), 0);
    check({tag, "_brk_cnt"}, int'(brk_cnt), 0);
  endtask

  initial begin
    logic [7:0] b;
    int         r;
    bit         bad, kind;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Single make code, held in the FIFO
    rdy_force = 1'b0;
    good(8'h1C);
    check("a_make_valid", int'(bus.out_valid), 1);
    check("a_make_level", int'(level), 1);
    check("a_make_data", int'(bus.out_data), 10'h01C);
    drain();

    // Prefix folding
    good(8'hF0); good(8'h1C);
    good(8'hE0); good(8'hF0); good(8'h75);
    drain();
    check_counters("prefix");

    // Bad parity and bad stop, with a pending break prefix that must be cleared
    good(8'hF0);
    send_frame(8'h1C, 1'b1, 1'b0, 11, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
    check("bad_level", int'(level), 0);
    good(8'h32);
    drain();
    check_counters("bad");

    // Overflow on a full FIFO
    rdy_force = 1'b0;
    for (int i = 0; i < 5; i++) good(8'h10 + 8'(i));
    check("ovf_level", int'(level), int'(DEPTH));
    check_counters("ovf");
    drain();

    // Full FIFO with a pop on the push cycle keeps the new event
    @(negedge clk); rst = 1'b1; model_reset();
    repeat (2) @(negedge clk); rst = 1'b0;
    rdy_force = 1'b0;
    for (int i = 0; i < 4; i++) good(8'h10 + 8'(i));
    send_frame(8'h14, 1'b0, 1'b0, 11, 1'b1);
    check("popush_level", int'(level), int'(DEPTH));
    check_counters("popush");
    drain();

    // Timeout mid-frame also clears a pending extended prefix
    good(8'hE0);
    send_frame(8'h55, 1'b0, 1'b0, 5, 1'b0);
    repeat (TMO + 50) @(posedge clk);
    model_abort();
    #1;
    check_counters("timeout");
    good(8'h2A);
    drain();

    // Async reset mid-frame with events queued
    rdy_force = 1'b0;
    good(8'hF0); good(8'h21); good(8'h22);
    check("prerst_level", int'(level), 2);
    send_frame(8'h33, 1'b0, 1'b0, 6, 1'b0);
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    good(8'h1C);
    drain();
    check_counters("postrst");

    // Randomized traffic with random consumer stalls
    rdy_rand = 1'b1;
    for (int n = 0; n < 60; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 15) b = 8'hE0;
      else if (r < 30) b = 8'hF0;
      else b = 8'($urandom_range(0, 255));
      bad  = ($urandom_range(0, 9) == 0);
      kind = 1'($urandom_range(0, 1));
      send_frame(b, bad && kind, bad && !kind, 11, 1'b0);
    end
    rdy_rand = 1'b0;
    drain();
    check_counters("random");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Hard stop so the bench can never hang
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
